apb_cmd_arbiter: RTL
====================

// Module: apb_cmd_arbiter
// PURPOSE
// - Shares one APB master command port ({write,wdata,addr} cmd / valid / {slverr,rdata} resp / ready) among NREQ requesters.
// - Requesters are the MCS I/O bridge plus later masters such as the debug/DMA path.
// - Round-robin grant; one transaction in flight at a time.
// - Optional watchdog returns an error response if the APB master never completes.
// PARAMETERS
// - NREQ     2    number of requesters (>=2)
// - DW       32   APB data width
// - AW       32   APB address width
// - TIMEOUT  255  watchdog limit in cycles (used only with APB_ARB_TIMEOUT_EN; >=1)
// - localparams:
//   - CW = 1+DW+AW   cmd layout {write, wdata, addr}
//   - RW = 1+DW      resp layout {slverr, rdata}
// PORTS
// - CLK        in   1        clock; all logic on posedge
// - RESET      in   1        synchronous, active-high reset
// - req_cmd    in   NREQ*CW  requester i cmd at [i*CW +: CW]
// - req_valid  in   NREQ     requester i has a pending cmd (level)
// - req_ready  out  NREQ     one-cycle pulse: requester i's transaction done
// - req_resp   out  RW       response, broadcast; valid when any req_ready bit is 1
// - m_cmd      out  CW       cmd to APB master (registered)
// - m_valid    out  1        one-cycle pulse: APB master starts m_cmd
// - m_resp     in   RW       APB master response
// - m_ready    in   1        APB master completion pulse
// - grant      out  NREQ     one-hot owner of the current transaction; 0 when idle
// - busy       out  1        1 in any state other than IDLE
// BEHAVIOUR
// - Reset values: state=IDLE, rr_ptr=0, m_valid=0, m_cmd=0, grant=0, req_ready=0, busy=0, req_resp=0.
// - Requester contract: hold req_valid and req_cmd stable until its req_ready pulse.
//   - Dropping req_valid before grant withdraws the request.
//   - Dropping it after grant: the transaction still completes and req_ready still pulses.
// - FSM IDLE -> ISSUE -> WAIT -> IDLE (plus DRAIN with the macro).
// - IDLE: if any req_valid:
//   - g = first set bit scanning rr_ptr, rr_ptr+1, ... mod NREQ
//   - register grant=onehot(g), m_cmd=req_cmd[g]
//   - go to ISSUE
// - ISSUE: m_valid=1 for exactly this cycle; rr_ptr <= (g+1) mod NREQ; go to WAIT.
//   - m_ready in ISSUE is ignored; the master completes no earlier than the cycle after m_valid.
// - WAIT: on m_ready:
//   - req_ready[g]=1 combinationally, req_resp=m_resp same cycle
//   - grant<=0, go to IDLE
// - Latency: req_valid seen at cycle 0 -> m_valid at cycle 1 -> req_ready in the m_ready cycle.
// - Back-to-back: IDLE re-arbitrates the cycle after completion.
// - Minimum spacing between m_valid pulses: 3 cycles.
// - req_resp = 0 whenever no req_ready bit is set.
// - m_ready outside WAIT/DRAIN is ignored; no response is produced.
// - Simultaneous requests: fairness by rr_ptr only.
//   - With all requesters continuously valid, grants rotate 0,1,...,NREQ-1,0.
// - RESET mid-transaction: return to IDLE next edge, no req_ready emitted.
//   - The APB master shares the same reset (inverted at top), so no stale m_ready follows.
// CONFIGURATION
// - APB_ARB_TIMEOUT_EN defined:
//   - In WAIT, the cycle counter starts at 0 at WAIT entry and increments each cycle.
//   - If it reaches TIMEOUT without m_ready:
//     - req_ready[g]=1 with req_resp={1'b1, DW'(0)}
//     - grant<=0, go to DRAIN
//   - DRAIN: busy=1, no arbitration; wait for m_ready, discard it (no req_ready), go to IDLE.
//   - m_ready in the same cycle as timeout: normal completion wins.
// - APB_ARB_TIMEOUT_EN undefined:
//   - No counter, no DRAIN state; WAIT holds until m_ready indefinitely.
//   - TIMEOUT is unused.
// TESTING
// - Write, req0:
//   - stimulus: req0 cmd={1,32'h1234_5678,32'hC000_0004}; m_ready 3 cycles after m_valid, m_resp={0,0}
//   - response: m_valid at cycle 1 with m_cmd equal to that cmd; req_ready=2'b01 with the m_ready pulse
// - Read, req1:
//   - stimulus: m_resp={0,32'hCAFE_0001}
//   - response: req_resp=33'h0_CAFE_0001 in the req_ready=2'b10 cycle
//   - m_resp={1,x} -> req_resp[DW]=1 passed through
// - Contention:
//   - stimulus: req0 and req1 both held valid from reset for 4 transactions
//   - response: grant sequence 01,10,01,10; m_valid spacing >= 3 cycles
// - Reset in WAIT:
//   - stimulus: RESET for 1 cycle
//   - response: next cycle busy=0, grant=0, m_valid=0; the following grant goes to req0 (rr_ptr=0)
// - Timeout (macro on, TIMEOUT=8):
//   - stimulus: master silent
//   - response: req_ready pulses 8 cycles after WAIT entry with req_resp={1,0}; busy=1 until a late m_ready, which produces no req_ready
// - Withdrawal:
//   - stimulus: req1 raises then drops valid while req0 owns the bus
//   - response: req1 never granted, no req_ready[1]

Source files
------------

// File: rtl/apb_cmd_arbiter.sv
// Round-robin arbiter sharing one APB master command port among NREQ requesters.
// Optional watchdog: define APB_ARB_TIMEOUT_EN to enable the WAIT timeout and DRAIN state.
module apb_cmd_arbiter #(
  parameter int NREQ    = 2,
  parameter int DW      = 32,
  parameter int AW      = 32,
  parameter int TIMEOUT = 255,
  localparam int CW     = 1 + DW + AW,
  localparam int RW     = 1 + DW
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic [NREQ*CW-1:0]   req_cmd,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  output logic [RW-1:0]        req_resp,
  output logic [CW-1:0]        m_cmd,
  output logic                 m_valid,
  input  logic [RW-1:0]        m_resp,
  input  logic                 m_ready,
  output logic [NREQ-1:0]      grant,
  output logic                 busy
);

  // state | meaning
  // IDLE  | no transaction; arbitrate among req_valid
  // ISSUE | m_valid pulse to the APB master, advance rr pointer
  // WAIT  | waiting for m_ready of the granted transaction
  // DRAIN | watchdog fired; swallow the late m_ready (watchdog build only)
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT
`ifdef APB_ARB_TIMEOUT_EN
    , ST_DRAIN
`endif
  } state_t;

  localparam int IW = $clog2(NREQ);

  // TIMEOUT only has an effect with the watchdog built in; a bad value builds nothing extra.
  if (TIMEOUT < 1) begin : g_timeout_unused
  end

  state_t          r_state;
  state_t          w_state_nxt;
  logic [IW-1:0]   r_rr_ptr;
  logic [IW-1:0]   r_gidx;
  logic [NREQ-1:0] r_grant;
  logic [CW-1:0]   r_cmd;
  logic            w_found;
  logic [IW-1:0]   w_gsel;
  logic [NREQ-1:0] w_gsel_oh;

`ifdef APB_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0]   r_cnt;
  logic            w_tmo;
  assign w_tmo = (r_cnt == TW'(TIMEOUT));
`endif

  // first valid requester at or after the round-robin pointer
  always_comb begin
    w_found = 1'b0;
    w_gsel  = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!w_found && req_valid[(int'(r_rr_ptr) + k) % NREQ]) begin
        w_found = 1'b1;
        w_gsel  = IW'((int'(r_rr_ptr) + k) % NREQ);
      end
    end
    w_gsel_oh = NREQ'(1) << w_gsel;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state  <= ST_IDLE;
      r_rr_ptr <= '0;
      r_gidx   <= '0;
      r_grant  <= '0;
      r_cmd    <= '0;
`ifdef APB_ARB_TIMEOUT_EN
      r_cnt    <= '0;
`endif
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        ST_IDLE: begin
          if (w_found) begin
            r_grant <= w_gsel_oh;
            r_cmd   <= req_cmd[int'(w_gsel)*CW +: CW];
            r_gidx  <= w_gsel;
          end
        end
        ST_ISSUE: begin
          r_rr_ptr <= IW'((int'(r_gidx) + 1) % NREQ);
`ifdef APB_ARB_TIMEOUT_EN
          r_cnt    <= '0;
`endif
        end
        ST_WAIT: begin
          if (m_ready) begin
            r_grant <= '0;
`ifdef APB_ARB_TIMEOUT_EN
          end else if (w_tmo) begin
            r_grant <= '0;
          end else begin
            r_cnt   <= r_cnt + 1'b1;
`endif
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    req_ready   = '0;
    req_resp    = '0;
    case (r_state)
      ST_IDLE: begin
        if (w_found) w_state_nxt = ST_ISSUE;
      end
      ST_ISSUE: begin
        w_state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        // normal completion wins over a same-cycle watchdog expiry
        if (m_ready) begin
          req_ready   = r_grant;
          req_resp    = m_resp;
          w_state_nxt = ST_IDLE;
`ifdef APB_ARB_TIMEOUT_EN
        end else if (w_tmo) begin
          req_ready   = r_grant;
          req_resp    = {1'b1, {DW{1'b0}}};
          w_state_nxt = ST_DRAIN;
`endif
        end
      end
`ifdef APB_ARB_TIMEOUT_EN
      ST_DRAIN: begin
        if (m_ready) w_state_nxt = ST_IDLE;
      end
`endif
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign m_valid = (r_state == ST_ISSUE);
  assign m_cmd   = r_cmd;
  assign grant   = r_grant;
  assign busy    = (r_state != ST_IDLE);

endmodule
